// File: rtl/shader_fetch.sv
// shader_fetch: runtime-writable program store that streams one instruction per cycle to the
// execute stage on each pixel start, plus the 6-bit frame-time counter.
module shader_fetch #(
   parameter int NUM_INSTR = 16,
   parameter int ADDR_W    = $clog2(NUM_INSTR)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              prog_we_i,
   input  logic [ADDR_W-1:0] prog_addr_i,
   input  logic [7:0]        prog_data_i,
   input  logic              start_i,
   input  logic              frame_i,
   output logic [7:0]        instr_o,
   output logic              execute_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [5:0]        time_o
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        instr_q, instr_d;
   logic              execute_q, execute_d, done_q, done_d;
   logic [5:0]        time_q, time_d;
   logic [7:0]        mem_q [NUM_INSTR];
   logic [7:0]        mem_d [NUM_INSTR];
   logic              fetch, last;
   // pc wraps to 0 on the final fetch, so IDLE and a back-to-back restart both fetch slot 0
   always_comb begin
      fetch     = (state_q == RUN) || start_i;
      last      = pc_q == ADDR_W'(NUM_INSTR - 1);
      mem_d     = mem_q;
      if (prog_we_i) mem_d[prog_addr_i] = prog_data_i;
      instr_d   = fetch ? mem_q[pc_q] : instr_q;
      execute_d = fetch;
      pc_d      = fetch ? pc_q + 1'b1 : pc_q;
      done_d    = (state_q == RUN) && last;
      state_d   = (((state_q == RUN) && !last) || start_i) ? RUN : IDLE;
      time_d    = time_q + 6'(frame_i);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         instr_q   <= 8'h40;
         execute_q <= 1'b0;
         done_q    <= 1'b0;
         time_q    <= '0;
         mem_q     <= '{default: 8'h40};
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         execute_q <= execute_d;
         done_q    <= done_d;
         time_q    <= time_d;
         mem_q     <= mem_d;
      end
   end
   assign instr_o   = instr_q;
   assign execute_o = execute_q;
   assign busy_o    = execute_q;
   assign done_o    = done_q;
   assign time_o    = time_q;
endmodule
